stopwatch_datapath: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 20 ++
 rtl/stopwatch_datapath_if.sv | 11 +
 rtl/stopwatch_datapath_bcd_digit.sv | 17 +
 rtl/stopwatch_datapath.sv | 48 ++++
 tb/tb_stopwatch_datapath.sv | 106 ++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: control-word layout, command encodings and BCD digit moduli
package stopwatch_pkg;
  localparam int CW_W = 6;
  localparam int SW_W = 3;
  localparam int PRE_LSB = 0;
  localparam int TIME_LSB = 2;
  localparam int DISP_LSB = 4;
  typedef enum logic [1:0] {CMD_HOLD = 2'b00, CMD_RUN = 2'b01, CMD_CLR = 2'b10} cmd_e;
  localparam cmd_e CMD_INC = CMD_RUN;
  localparam cmd_e CMD_LOAD = CMD_RUN;
  localparam int MOD_TENTHS = 10;
  localparam int MOD_SEC_UNITS = 10;
  localparam int MOD_SEC_TENS = 6;
  localparam int MOD_MIN = 10;
  localparam int DIGIT_MOD [4] = '{MOD_TENTHS, MOD_SEC_UNITS, MOD_SEC_TENS, MOD_MIN};
  // 2'b11 decodes as clear, same as CMD_CLR, because only the msb is tested
  function automatic cmd_e field(input logic [CW_W-1:0] cw, input int lsb);
    return cmd_e'(cw[lsb +: 2]);
  endfunction
endpackage

// File: rtl/stopwatch_datapath_if.sv
// stopwatch_datapath_if: control word in, status and BCD time/display out
interface stopwatch_datapath_if;
  import stopwatch_pkg::*;
  logic [CW_W-1:0] cw;
  logic tenth;
  logic [15:0] time_bcd;
  logic [15:0] disp_bcd;
  logic rollover;
  modport master(output cw, input tenth, time_bcd, disp_bcd, rollover);
  modport slave(input cw, output tenth, time_bcd, disp_bcd, rollover);
endinterface

// File: rtl/stopwatch_datapath_bcd_digit.sv
// bcd_digit: one modulo-MODULUS BCD digit of the elapsed-time carry chain
module bcd_digit #(
  parameter int MODULUS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc_in,
  output logic [3:0] q,
  output logic       carry_out
);
  localparam logic [3:0] TOP = 4'(MODULUS - 1);
  assign carry_out = inc_in & (q == TOP);
  always_ff @(posedge clk)
    if (reset || clr) q <= '0;
    else if (inc_in) q <= (q == TOP) ? '0 : q + 4'd1;
endmodule

// File: rtl/stopwatch_datapath.sv
// stopwatch_datapath: prescaler, BCD M:SS.T counter and lap/display register
module stopwatch_datapath
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_TENTH = 5000000
) (
  input logic clk,
  input logic reset,
  stopwatch_datapath_if.slave bus
);
  localparam int PW = $clog2(TICKS_PER_TENTH);
  localparam logic [PW-1:0] TERM = PW'(TICKS_PER_TENTH - 1);
  logic [PW-1:0] pre;
  logic [15:0] time_q;
  logic [15:0] disp_q;
  logic roll_q;
  logic [4:0] carry;
  cmd_e pre_cmd, time_cmd, disp_cmd;
  assign pre_cmd = field(bus.cw, PRE_LSB);
  assign time_cmd = field(bus.cw, TIME_LSB);
  assign disp_cmd = field(bus.cw, DISP_LSB);
  assign bus.tenth = pre == TERM;
  assign bus.time_bcd = time_q;
  assign bus.disp_bcd = disp_q;
  assign bus.rollover = roll_q;
  assign carry[0] = time_cmd == CMD_INC;
  for (genvar i = 0; i < 4; i++) begin : g_digit
    bcd_digit #(.MODULUS(DIGIT_MOD[i])) u_digit (
      .clk(clk),
      .reset(reset),
      .clr(time_cmd[1]),
      .inc_in(carry[i]),
      .q(time_q[4*i +: 4]),
      .carry_out(carry[i+1])
    );
  end
  // carry out of the minutes digit is exactly the 9:59.9 -> 0:00.0 wrap
  always_ff @(posedge clk)
    if (reset) begin
      pre <= '0;
      disp_q <= '0;
      roll_q <= 1'b0;
    end else begin
      pre <= pre_cmd[1] ? '0 : (pre_cmd == CMD_RUN) ? (bus.tenth ? '0 : pre + 1'b1) : pre;
      disp_q <= disp_cmd[1] ? '0 : (disp_cmd == CMD_LOAD) ? time_q : disp_q;
      roll_q <= carry[4];
    end
endmodule

// File: tb/tb_stopwatch_datapath.sv
// tb_stopwatch_datapath: directed checks of prescaler, BCD carry chain, wrap and lap register
module tb_stopwatch_datapath;
  logic clk;
  logic reset;
  int total = 0;
  int bad = 0;
  stopwatch_datapath_if bus();
  stopwatch_datapath #(.TICKS_PER_TENTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #10 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b1;
    bus.cw = 6'b101110;
    step(1);
    chk("rst_time", bus.time_bcd, 16'h0000);
    chk("rst_disp", bus.disp_bcd, 16'h0000);
    chk("rst_roll", {15'd0, bus.rollover}, 16'h0000);
    chk("rst_tenth", {15'd0, bus.tenth}, 16'h0000);
    bus.cw = 6'b010101;
    step(2);
    chk("rst_hold_time", bus.time_bcd, 16'h0000);
    chk("rst_hold_disp", bus.disp_bcd, 16'h0000);
    chk("rst_hold_tenth", {15'd0, bus.tenth}, 16'h0000);
    reset = 1'b0;
    bus.cw = 6'b000001;
    for (int k = 1; k <= 12; k++) begin
      chk($sformatf("tenth_cyc%0d", k), {15'd0, bus.tenth}, {15'd0, k % 4 == 0});
      step(1);
    end
    step(3);
    bus.cw = 6'b000000;
    chk("tenth_held0", {15'd0, bus.tenth}, 16'h0001);
    step(2);
    chk("tenth_held2", {15'd0, bus.tenth}, 16'h0001);
    chk("time_idle", bus.time_bcd, 16'h0000);
    bus.cw = 6'b000100;
    step(99);
    chk("time_0099", bus.time_bcd, 16'h0099);
    step(1);
    chk("carry_sec", bus.time_bcd, 16'h0100);
    step(499);
    chk("time_0599", bus.time_bcd, 16'h0599);
    step(1);
    chk("carry_min", bus.time_bcd, 16'h1000);
    step(5399);
    chk("time_9599", bus.time_bcd, 16'h9599);
    chk("roll_pre", {15'd0, bus.rollover}, 16'h0000);
    step(1);
    chk("wrap_time", bus.time_bcd, 16'h0000);
    chk("wrap_roll", {15'd0, bus.rollover}, 16'h0001);
    bus.cw = 6'b000000;
    step(1);
    chk("roll_once", {15'd0, bus.rollover}, 16'h0000);
    chk("wrap_hold", bus.time_bcd, 16'h0000);
    bus.cw = 6'b000100;
    step(32);
    chk("time_0032", bus.time_bcd, 16'h0032);
    chk("disp_idle", bus.disp_bcd, 16'h0000);
    bus.cw = 6'b010100;
    step(1);
    chk("lap_load", bus.disp_bcd, 16'h0032);
    chk("lap_time", bus.time_bcd, 16'h0033);
    bus.cw = 6'b000100;
    step(7);
    chk("lap_time40", bus.time_bcd, 16'h0040);
    chk("lap_freeze", bus.disp_bcd, 16'h0032);
    bus.cw = 6'b011000;
    step(1);
    chk("clr_load_disp", bus.disp_bcd, 16'h0040);
    chk("clr_load_time", bus.time_bcd, 16'h0000);
    bus.cw = 6'b100100;
    step(1);
    chk("disp_clr", bus.disp_bcd, 16'h0000);
    chk("inc_with_clr", bus.time_bcd, 16'h0001);
    bus.cw = 6'b000110;
    step(1);
    chk("pre_clr", {15'd0, bus.tenth}, 16'h0000);
    chk("inc_pre_clr", bus.time_bcd, 16'h0002);
    bus.cw = 6'b010101;
    step(2);
    reset = 1'b1;
    step(1);
    chk("midrst_time", bus.time_bcd, 16'h0000);
    chk("midrst_disp", bus.disp_bcd, 16'h0000);
    chk("midrst_tenth", {15'd0, bus.tenth}, 16'h0000);
    reset = 1'b0;
    bus.cw = 6'b000001;
    step(2);
    chk("post_rst_pre2", {15'd0, bus.tenth}, 16'h0000);
    step(1);
    chk("post_rst_pre3", {15'd0, bus.tenth}, 16'h0001);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
